prv_trap_ctrl: RTL

Trap controller inside the priv block, on the priv-block side of the pipeline/priv link.
- Consumes exception flags, `ret`, `pipe_clear`, `epc` and `badaddr` from the hazard unit, plus the interrupt lines.
- Prioritises traps and updates `mepc`, `mcause`, `mtval`, `mstatus.MIE` and `mstatus.MPIE`.
- Drives `intr`, `insert_pc` and `priv_pc` back to the hazard unit to redirect fetch on a trap or `mret`.

---
 rtl/machine_mode_types_pkg.sv | 41 ++++
 rtl/prv_trap_prio.sv | 66 ++++++
 rtl/prv_trap_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/machine_mode_types_pkg.sv
// Machine-mode trap types shared by the trap controller.
// Cause codes, trap FSM encoding and mcause helpers.
package machine_mode_types_pkg;

  typedef enum logic [3:0] {
    EX_MAL_INSN   = 4'd0,
    EX_FAULT_INSN = 4'd1,
    EX_ILLEGAL    = 4'd2,
    EX_BREAK      = 4'd3,
    EX_MAL_L      = 4'd4,
    EX_FAULT_L    = 4'd5,
    EX_MAL_S      = 4'd6,
    EX_FAULT_S    = 4'd7,
    EX_ENV_M      = 4'd11
  } ex_code_t;

  typedef enum logic [3:0] {
    INT_SOFT  = 4'd3,
    INT_TIMER = 4'd7,
    INT_EXT   = 4'd11
  } int_code_t;

  typedef logic [1:0] trap_state_t;

  localparam trap_state_t ST_IDLE     = 2'd0;
  localparam trap_state_t ST_WAIT_CLR = 2'd1;
  localparam trap_state_t ST_INSERT   = 2'd2;

  localparam int MCAUSE_INT_BIT = 31;

  function automatic logic [31:0] mk_mcause(
    input logic       is_int,
    input logic [3:0] code
  );
    logic [31:0] r;
    r = {28'd0, code};
    r[MCAUSE_INT_BIT] = is_int;
    return r;
  endfunction

endpackage

// File: rtl/prv_trap_prio.sv
// Trap priority encoder: exceptions first, then ext/soft/timer.
// Purely combinational; eligibility is resolved by the caller.
module prv_trap_prio
  import machine_mode_types_pkg::*;
(
  input  logic       fault_insn,
  input  logic       mal_insn,
  input  logic       illegal_insn,
  input  logic       fault_l,
  input  logic       mal_l,
  input  logic       fault_s,
  input  logic       mal_s,
  input  logic       breakpoint,
  input  logic       env_m,
  input  logic [2:0] int_elig,
  output logic       valid,
  output logic       is_int,
  output logic [3:0] code,
  output logic       use_badaddr
);

  // Fixed-priority select of the winning cause
  always_comb begin
    valid       = 1'b1;
    is_int      = 1'b0;
    use_badaddr = 1'b0;
    code        = EX_MAL_INSN;
    if (breakpoint) begin
      code = EX_BREAK;
    end else if (fault_insn) begin
      code        = EX_FAULT_INSN;
      use_badaddr = 1'b1;
    end else if (mal_insn) begin
      code        = EX_MAL_INSN;
      use_badaddr = 1'b1;
    end else if (illegal_insn) begin
      code = EX_ILLEGAL;
    end else if (env_m) begin
      code = EX_ENV_M;
    end else if (mal_l) begin
      code        = EX_MAL_L;
      use_badaddr = 1'b1;
    end else if (mal_s) begin
      code        = EX_MAL_S;
      use_badaddr = 1'b1;
    end else if (fault_l) begin
      code        = EX_FAULT_L;
      use_badaddr = 1'b1;
    end else if (fault_s) begin
      code        = EX_FAULT_S;
      use_badaddr = 1'b1;
    end else if (int_elig[2]) begin
      is_int = 1'b1;
      code   = INT_EXT;
    end else if (int_elig[0]) begin
      is_int = 1'b1;
      code   = INT_SOFT;
    end else if (int_elig[1]) begin
      is_int = 1'b1;
      code   = INT_TIMER;
    end else begin
      valid = 1'b0;
    end
  end

endmodule

// File: rtl/prv_trap_ctrl.sv
// Machine-mode trap controller: latches traps/mret, commits CSRs
// at pipe_clear, redirects fetch. Option: PRV_VECTORED_INTR_EN.
module prv_trap_ctrl
  import machine_mode_types_pkg::*;
#(
  parameter logic [31:0] RESET_MEPC    = 32'h0000_0000,
  parameter int          TRAP_HOLD_MAX = 15
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        fault_insn,
  input  logic        mal_insn,
  input  logic        illegal_insn,
  input  logic        fault_l,
  input  logic        mal_l,
  input  logic        fault_s,
  input  logic        mal_s,
  input  logic        breakpoint,
  input  logic        env_m,
  input  logic        ret,
  input  logic        pipe_clear,
  input  logic [31:0] epc,
  input  logic [31:0] badaddr,
  input  logic        timer_int,
  input  logic        soft_int,
  input  logic        ext_int,
  input  logic [2:0]  mie_en,
  input  logic [31:0] mtvec,
  output logic [31:0] priv_pc,
  output logic        insert_pc,
  output logic        intr,
  output logic [31:0] mepc,
  output logic [31:0] mcause,
  output logic [31:0] mtval,
  output logic        mstatus_mie,
  output logic        mstatus_mpie,
  output logic        clr_timeout
);

  localparam int CW = $clog2(TRAP_HOLD_MAX + 1);
  localparam logic [CW-1:0] HOLD_MAX  = CW'(TRAP_HOLD_MAX);
  localparam logic [CW-1:0] HOLD_LAST = CW'(TRAP_HOLD_MAX - 1);

  trap_state_t   state_q, state_d;
  logic [CW-1:0] hold_q, hold_d;
  logic          to_q, to_d;

  logic          lat_int_q, lat_int_d;
  logic          lat_ret_q, lat_ret_d;
  logic [3:0]    lat_code_q, lat_code_d;
  logic          lat_bad_q, lat_bad_d;
  logic [31:0]   lat_epc_q, lat_epc_d;
  logic [31:0]   lat_addr_q, lat_addr_d;

  logic [31:0]   mepc_q, mepc_d;
  logic [31:0]   mcause_q, mcause_d;
  logic [31:0]   mtval_q, mtval_d;
  logic          mie_q, mie_d;
  logic          mpie_q, mpie_d;
  logic [31:0]   ppc_q, ppc_d;

  logic          commit;
  logic [31:0]   tgt;
  logic [2:0]    elig;
  logic          p_valid, p_int, p_bad;
  logic [3:0]    p_code;
  logic          p_exc, p_irq;

  assign elig = {ext_int, timer_int, soft_int}
              & mie_en & {3{mie_q}};

  prv_trap_prio u_prio (
    .fault_insn   (fault_insn),
    .mal_insn     (mal_insn),
    .illegal_insn (illegal_insn),
    .fault_l      (fault_l),
    .mal_l        (mal_l),
    .fault_s      (fault_s),
    .mal_s        (mal_s),
    .breakpoint   (breakpoint),
    .env_m        (env_m),
    .int_elig     (elig),
    .valid        (p_valid),
    .is_int       (p_int),
    .code         (p_code),
    .use_badaddr  (p_bad)
  );

  assign p_exc = p_valid & ~p_int;
  assign p_irq = p_valid & p_int;

  // Trap FSM: latch a cause, wait for drain, flag slow drains
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    to_d       = to_q;
    lat_int_d  = lat_int_q;
    lat_ret_d  = lat_ret_q;
    lat_code_d = lat_code_q;
    lat_bad_d  = lat_bad_q;
    lat_epc_d  = lat_epc_q;
    lat_addr_d = lat_addr_q;
    commit     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        hold_d = '0;
        if (p_exc || (p_irq && !ret)) begin
          lat_int_d  = p_int;
          lat_ret_d  = 1'b0;
          lat_code_d = p_code;
          lat_bad_d  = p_bad;
          lat_epc_d  = epc;
          lat_addr_d = badaddr;
          commit     = pipe_clear;
          state_d    = pipe_clear ? ST_INSERT
                                  : ST_WAIT_CLR;
        end else if (ret) begin
          lat_int_d = 1'b0;
          lat_ret_d = 1'b1;
          commit    = pipe_clear;
          state_d   = pipe_clear ? ST_INSERT
                                 : ST_WAIT_CLR;
        end
      end
      ST_WAIT_CLR: begin
        // an exception outranks a parked interrupt or mret
        if (p_exc && (lat_int_q || lat_ret_q)) begin
          lat_int_d  = 1'b0;
          lat_ret_d  = 1'b0;
          lat_code_d = p_code;
          lat_bad_d  = p_bad;
          lat_epc_d  = epc;
          lat_addr_d = badaddr;
        end
        if (pipe_clear) begin
          commit  = 1'b1;
          hold_d  = '0;
          state_d = ST_INSERT;
        end else begin
          if (hold_q != HOLD_MAX) hold_d = hold_q + CW'(1);
          if (hold_q >= HOLD_LAST) to_d = 1'b1;
        end
      end
      ST_INSERT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // CSR and redirect updates at the commit point
  always_comb begin
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    mtval_d  = mtval_q;
    mie_d    = mie_q;
    mpie_d   = mpie_q;
    ppc_d    = ppc_q;
    tgt      = {mtvec[31:2], 2'b00};
`ifdef PRV_VECTORED_INTR_EN
    if (lat_int_d && (mtvec[1:0] == 2'b01))
      tgt = tgt + {26'd0, lat_code_d, 2'b00};
`endif
    if (commit) begin
      if (lat_ret_d) begin
        mie_d  = mpie_q;
        mpie_d = 1'b1;
        ppc_d  = mepc_q;
      end else begin
        mepc_d   = lat_epc_d;
        mcause_d = mk_mcause(lat_int_d, lat_code_d);
        mtval_d  = lat_bad_d ? lat_addr_d : 32'd0;
        mpie_d   = mie_q;
        mie_d    = 1'b0;
        ppc_d    = tgt;
      end
    end
  end

`ifndef PRV_VECTORED_INTR_EN
  logic unused_mtvec_lo;
  assign unused_mtvec_lo = ^mtvec[1:0];
`endif

  // State and CSR registers, synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      to_q       <= 1'b0;
      lat_int_q  <= 1'b0;
      lat_ret_q  <= 1'b0;
      lat_code_q <= '0;
      lat_bad_q  <= 1'b0;
      lat_epc_q  <= '0;
      lat_addr_q <= '0;
      mepc_q     <= RESET_MEPC;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      ppc_q      <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      to_q       <= to_d;
      lat_int_q  <= lat_int_d;
      lat_ret_q  <= lat_ret_d;
      lat_code_q <= lat_code_d;
      lat_bad_q  <= lat_bad_d;
      lat_epc_q  <= lat_epc_d;
      lat_addr_q <= lat_addr_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      ppc_q      <= ppc_d;
    end
  end

  assign insert_pc    = (state_q == ST_INSERT);
  assign intr         = !p_exc &&
                        (((state_q == ST_IDLE) && |elig) ||
                         ((state_q == ST_WAIT_CLR) && lat_int_q));
  assign priv_pc      = ppc_q;
  assign mepc         = mepc_q;
  assign mcause       = mcause_q;
  assign mtval        = mtval_q;
  assign mstatus_mie  = mie_q;
  assign mstatus_mpie = mpie_q;
  assign clr_timeout  = to_q;

endmodule
